// File: rtl/prng_gen.sv
// rtl/prng_gen.sv - parametrised LCG / Galois-LFSR random word generator with seed handshake and reseed request
// Optional macro PRNG_WHITEN_EN: output word is x ^ (x >> WIDTH/2); internal state is unaffected.
module prng_gen #(
  parameter int          WIDTH         = 16,
  parameter int          MODE          = 0,
  parameter logic [31:0] MULT          = 32'd25173,
  parameter logic [31:0] INC           = 32'd13849,
  parameter logic [31:0] TAPS          = 32'h0000_B400,
  parameter logic [31:0] DEFAULT_SEED  = 32'h0000_ACE1,
  parameter int          RESEED_PERIOD = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             seed_valid,
  output logic             seed_ready,
  input  logic             enable,
  output logic [WIDTH-1:0] num,
  output logic             num_valid,
  input  logic             num_ready,
  output logic             reseed_req
);

  localparam int CW = (RESEED_PERIOD == 0) ? 1 :
                      (($clog2(RESEED_PERIOD + 1) < 1) ? 1 : $clog2(RESEED_PERIOD + 1));

  localparam logic [WIDTH-1:0] MULT_W = MULT[WIDTH-1:0];
  localparam logic [WIDTH-1:0] INC_W  = INC[WIDTH-1:0];
  localparam logic [WIDTH-1:0] TAPS_W = TAPS[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SEED_W = DEFAULT_SEED[WIDTH-1:0];
  localparam logic [CW-1:0]    PERIOD_W = CW'(RESEED_PERIOD);

  typedef enum logic [1:0] {
    ST_UNSEEDED = 2'd0,
    ST_PRIME    = 2'd1,
    ST_RUN      = 2'd2
  } state_t;

  state_t           r_fsm;
  state_t           w_fsm_nxt;
  logic [WIDTH-1:0] r_state;
  logic [WIDTH-1:0] r_num;
  logic             r_num_valid;
  logic             r_reseed_req;
  logic [CW-1:0]    r_count;

  logic             w_seed_ready;
  logic             w_seed_acc;
  logic             w_word_acc;
  logic [WIDTH-1:0] w_seed_load;
  logic [WIDTH-1:0] w_lcg_next;
  logic [WIDTH-1:0] w_lfsr_next;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_out;
  logic [CW-1:0]    w_count_inc;
  logic             w_period_hit;

  // Product is computed at WIDTH bits, so it is truncated modulo 2^WIDTH.
  assign w_lcg_next  = (r_state * MULT_W) + INC_W;
  assign w_lfsr_next = (r_state >> 1) ^ (r_state[0] ? TAPS_W : '0);
  assign w_next      = (MODE == 1) ? w_lfsr_next : w_lcg_next;

`ifdef PRNG_WHITEN_EN
  assign w_out = w_next ^ (w_next >> (WIDTH / 2));
`else
  assign w_out = w_next;
`endif

  // A zero LFSR state would lock up, so a zero seed falls back to the default.
  assign w_seed_load = ((MODE == 1) && (seed_in == '0)) ? SEED_W : seed_in;

  assign w_seed_acc   = seed_valid & w_seed_ready;
  assign w_word_acc   = (r_fsm == ST_RUN) & r_num_valid & num_ready & enable;
  assign w_count_inc  = (&r_count) ? r_count : r_count + 1'b1;
  assign w_period_hit = (RESEED_PERIOD != 0) && (w_count_inc == PERIOD_W);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_fsm <= ST_UNSEEDED;
    end else begin
      r_fsm <= w_fsm_nxt;
    end
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      ST_UNSEEDED: if (w_seed_acc) w_fsm_nxt = ST_PRIME;
      ST_PRIME:    w_fsm_nxt = ST_RUN;
      ST_RUN:      if (w_seed_acc) w_fsm_nxt = ST_PRIME;
      default:     w_fsm_nxt = ST_UNSEEDED;
    endcase
  end

  always_comb begin
    w_seed_ready = 1'b1;
    if (r_fsm == ST_PRIME) begin
      w_seed_ready = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= SEED_W;
      r_num        <= '0;
      r_num_valid  <= 1'b0;
      r_reseed_req <= 1'b0;
      r_count      <= '0;
    end else if (w_seed_acc) begin
      r_state      <= w_seed_load;
      r_num_valid  <= 1'b0;
      r_reseed_req <= 1'b0;
    end else if (r_fsm == ST_PRIME) begin
      r_state      <= w_next;
      r_num        <= w_out;
      r_num_valid  <= 1'b1;
      r_count      <= '0;
      r_reseed_req <= 1'b0;
    end else if (w_word_acc) begin
      r_state      <= w_next;
      r_num        <= w_out;
      r_count      <= w_count_inc;
      r_reseed_req <= r_reseed_req | w_period_hit;
    end
  end

  assign seed_ready = w_seed_ready;
  assign num        = r_num;
  assign num_valid  = r_num_valid;
  assign reseed_req = r_reseed_req;

endmodule

// File: tb/tb_prng_gen.sv
// tb/tb_prng_gen.sv - directed bench for prng_gen: LCG instance with reseed period 4, LFSR instance with defaults
module tb_prng_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        en;

  logic [15:0] a_seed;
  logic        a_sv;
  logic        a_sr;
  logic [15:0] a_num;
  logic        a_nv;
  logic        a_nr;
  logic        a_req;

  logic [15:0] b_seed;
  logic        b_sv;
  logic        b_sr;
  logic [15:0] b_num;
  logic        b_nv;
  logic        b_nr;
  logic        b_req;

  int total = 0;
  int bad   = 0;
  logic [15:0] m;

  prng_gen #(.WIDTH(16), .MODE(0), .RESEED_PERIOD(4)) u_lcg (
    .clk(clk), .rst(rst), .seed_in(a_seed), .seed_valid(a_sv), .seed_ready(a_sr),
    .enable(en), .num(a_num), .num_valid(a_nv), .num_ready(a_nr), .reseed_req(a_req)
  );

  prng_gen #(.WIDTH(16), .MODE(1), .TAPS(32'h0000_B400)) u_lfsr (
    .clk(clk), .rst(rst), .seed_in(b_seed), .seed_valid(b_sv), .seed_ready(b_sr),
    .enable(en), .num(b_num), .num_valid(b_nv), .num_ready(b_nr), .reseed_req(b_req)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] lcg_next(input logic [15:0] x);
    logic [31:0] p;
    p = 32'(x) * 32'd25173 + 32'd13849;
    return p[15:0];
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
  endfunction

  function automatic logic [15:0] exp_f(input logic [15:0] x);
`ifdef PRNG_WHITEN_EN
    return x ^ (x >> 8);
`else
    return x;
`endif
  endfunction

  initial begin
    rst = 1'b0; en = 1'b1;
    a_seed = '0; a_sv = 1'b0; a_nr = 1'b0;
    b_seed = '0; b_sv = 1'b0; b_nr = 1'b0;
    step(); step();
    rst = 1'b1;
    chk("rst_num", 32'(a_num), 32'h0);
    chk("rst_valid", 32'(a_nv), 32'h0);
    chk("rst_req", 32'(a_req), 32'h0);
    chk("rst_seed_ready", 32'(a_sr), 32'h1);

    // LCG seed 1: first word 986E (98F6 whitened), then EE9F
    a_seed = 16'h0001; a_sv = 1'b1; a_nr = 1'b1;
    step();
    a_sv = 1'b0;
    chk("prime_valid", 32'(a_nv), 32'h0);
    chk("prime_seed_ready", 32'(a_sr), 32'h0);
    step();
    chk("first_valid", 32'(a_nv), 32'h1);
`ifdef PRNG_WHITEN_EN
    chk("first_word", 32'(a_num), 32'h98F6);
`else
    chk("first_word", 32'(a_num), 32'h986E);
`endif
    step();
    chk("second_word", 32'(a_num), 32'(exp_f(16'hEE9F)));
    m = 16'hEE9F;

    a_nr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_ready_num", 32'(a_num), 32'(exp_f(m)));
      chk("bp_ready_valid", 32'(a_nv), 32'h1);
    end
    en = 1'b0; a_nr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_enable_num", 32'(a_num), 32'(exp_f(m)));
      chk("bp_enable_valid", 32'(a_nv), 32'h1);
      chk("bp_enable_req", 32'(a_req), 32'h0);
    end
    en = 1'b1;
    for (int k = 2; k <= 6; k++) begin
      step();
      m = lcg_next(m);
      chk("run_word", 32'(a_num), 32'(exp_f(m)));
      chk("reseed_req", 32'(a_req), (k >= 4) ? 32'h1 : 32'h0);
    end

    // Seed handshake coinciding with a word accept
    a_seed = 16'h1234; a_sv = 1'b1;
    step();
    a_sv = 1'b0;
    chk("reseed_valid", 32'(a_nv), 32'h0);
    chk("reseed_seed_ready", 32'(a_sr), 32'h0);
    chk("reseed_req_clr", 32'(a_req), 32'h0);
    step();
    m = lcg_next(16'h1234);
    chk("reseed_first_valid", 32'(a_nv), 32'h1);
    chk("reseed_first_word", 32'(a_num), 32'(exp_f(m)));
    step();
    m = lcg_next(m);
    chk("reseed_second_word", 32'(a_num), 32'(exp_f(m)));

    // Reset mid-stream overrides a pending seed handshake
    a_seed = 16'h5555; a_sv = 1'b1; rst = 1'b0;
    step();
    chk("mid_rst_num", 32'(a_num), 32'h0);
    chk("mid_rst_valid", 32'(a_nv), 32'h0);
    chk("mid_rst_req", 32'(a_req), 32'h0);
    chk("mid_rst_seed_ready", 32'(a_sr), 32'h1);
    chk("mid_rst_state", 32'(u_lcg.r_state), 32'hACE1);
    rst = 1'b1; a_sv = 1'b0;
    step();

    // LFSR: seed ACE1 gives E270; a zero seed behaves as ACE1
    b_seed = 16'hACE1; b_sv = 1'b1;
    step();
    b_sv = 1'b0;
    step();
    chk("lfsr_first_valid", 32'(b_nv), 32'h1);
    chk("lfsr_first_word", 32'(b_num), 32'(exp_f(16'hE270)));
    b_seed = 16'h0000; b_sv = 1'b1;
    step();
    b_sv = 1'b0;
    chk("lfsr_zero_prime_valid", 32'(b_nv), 32'h0);
    step();
    chk("lfsr_zero_seed_word", 32'(b_num), 32'(exp_f(16'hE270)));
    m = 16'hE270;
    b_nr = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      step();
      m = lfsr_next(m);
      chk("lfsr_seq", 32'(b_num), 32'(exp_f(m)));
      chk("lfsr_nonzero", 32'(b_num != 16'h0), 32'h1);
    end
    chk("lfsr_no_reseed", 32'(b_req), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
